// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// default address map and size-mask helpers.
package mem_bus_ctrl_pkg;

  localparam logic [63:0] DM_BASE_DEF   = 64'h2000;
  localparam int          DM_ADDR_W_DEF = 13;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  // Byte-enable pattern of an access before it is shifted into its lane.
  function automatic logic [7:0] lane_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   lane_mask = 8'h01;
      2'b01:   lane_mask = 8'h03;
      2'b10:   lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Request/response port between the datapath (master) and the load/store unit (slave).
interface mem_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bus_ctrl_lsu_align.sv
// Combinational alignment helper: access alignment check, load lane extraction
// with sign/zero extension, and sub-doubleword store byte merge.
module mem_bus_ctrl_lsu_align
  import mem_bus_ctrl_pkg::*;
(
  input  logic [2:0]  chk_funct3,
  input  logic [2:0]  chk_addr_lo,
  output logic        misaligned,
  input  logic [2:0]  funct3,
  input  logic [2:0]  addr_lo,
  input  logic        is_im,
  input  logic [31:0] im_rdata,
  input  logic [63:0] dm_rdata,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [63:0] raw_s;
  logic [63:0] lane_s;
  logic [5:0]  shamt_s;
  logic        sext_s;
  logic [7:0]  wmask_s;
  logic [63:0] wdata_sh_s;

  assign misaligned = (chk_addr_lo & align_mask(chk_funct3)) != 3'b000;

  // Load path: an IM word is only four bytes wide, so addr[2] plays no part there
  always_comb begin
    raw_s     = dm_rdata;
    shamt_s   = {addr_lo, 3'b000};
    if (is_im) begin
      raw_s   = {32'h0000_0000, im_rdata};
      shamt_s = {1'b0, addr_lo[1:0], 3'b000};
    end else begin
      raw_s   = dm_rdata;
      shamt_s = {addr_lo, 3'b000};
    end
    lane_s = raw_s >> shamt_s;
    sext_s = ~funct3[2];
    case (funct3[1:0])
      2'b00:   load_data = {{56{sext_s & lane_s[7]}},  lane_s[7:0]};
      2'b01:   load_data = {{48{sext_s & lane_s[15]}}, lane_s[15:0]};
      2'b10:   load_data = {{32{sext_s & lane_s[31]}}, lane_s[31:0]};
      default: load_data = lane_s;
    endcase
  end

  // Store merge: replace the addressed bytes of the old doubleword with low wdata bytes
  always_comb begin
    merged     = dm_rdata;
    wmask_s    = lane_mask(funct3) << addr_lo;
    wdata_sh_s = wdata << {addr_lo, 3'b000};
    for (int i = 0; i < 8; i++) begin
      if (wmask_s[i]) begin
        merged[8*i +: 8] = wdata_sh_s[8*i +: 8];
      end else begin
        merged[8*i +: 8] = dm_rdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Load/store unit: decodes IM/DM address space, sequences loads, stores and
// read-modify-write sub-doubleword stores, and reports illegal accesses.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter logic [63:0] DM_BASE   = DM_BASE_DEF,
  parameter int          DM_ADDR_W = DM_ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_bus_ctrl_if.slave        bus,
  output logic [61:0]          im_addr,
  input  logic [31:0]          im_rdata,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic                 dm_we,
  output logic [63:0]          dm_wdata,
  input  logic [63:0]          dm_rdata
);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [2:0]             funct3_r;
  logic [63:0]            addr_r;
  logic [63:0]            wdata_r;
  logic                   is_im_r;
  logic [DM_ADDR_W-1:0]   dm_idx_r;
  logic [63:0]            dm_wdata_r;
  logic                   dm_we_r;
  logic                   req_ready_r;
  logic                   rsp_valid_r;
  logic [63:0]            rsp_rdata_r;
  logic                   rsp_err_r;
  logic [63:0]            req_off_s;
  logic                   req_im_s;
  logic                   req_err_s;
  logic                   misaligned_s;
  logic [63:0]            load_data_s;
  logic [63:0]            merged_s;

  assign req_im_s  = bus.req_addr < DM_BASE;
  assign req_off_s = bus.req_addr - DM_BASE;
  assign req_err_s = misaligned_s
                   | (bus.req_funct3 == F3_BAD)
                   | (bus.req_we & bus.req_funct3[2])
                   | (bus.req_we & req_im_s)
                   | ((bus.req_funct3 == F3_D) & req_im_s)
                   | (~req_im_s & (req_off_s >= (64'd1 << (DM_ADDR_W + 3))));

  mem_bus_ctrl_lsu_align u_align (
    .chk_funct3 (bus.req_funct3),
    .chk_addr_lo(bus.req_addr[2:0]),
    .misaligned (misaligned_s),
    .funct3     (funct3_r),
    .addr_lo    (addr_r[2:0]),
    .is_im      (is_im_r),
    .im_rdata   (im_rdata),
    .dm_rdata   (dm_rdata),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .merged     (merged_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; the store path is chosen at accept
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_err_s) begin
            state_nxt_s = ST_RESP;
          end else if (!bus.req_we) begin
            state_nxt_s = ST_LOAD;
          end else if (bus.req_funct3 == F3_D) begin
            state_nxt_s = ST_WRITE;
          end else begin
            state_nxt_s = ST_RMW_RD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD:   state_nxt_s = ST_RESP;
      ST_WRITE:  state_nxt_s = ST_RESP;
      ST_RMW_RD: state_nxt_s = ST_RMW_WR;
      ST_RMW_WR: state_nxt_s = ST_RESP;
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Request latches, merge register and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct3_r    <= 3'b000;
      addr_r      <= 64'd0;
      wdata_r     <= 64'd0;
      is_im_r     <= 1'b0;
      dm_idx_r    <= '0;
      dm_wdata_r  <= 64'd0;
      dm_we_r     <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 64'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == ST_IDLE);
      rsp_valid_r <= (state_nxt_s == ST_RESP);
      dm_we_r     <= (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_RMW_WR);
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            funct3_r   <= bus.req_funct3;
            addr_r     <= bus.req_addr;
            wdata_r    <= bus.req_wdata;
            is_im_r    <= req_im_s;
            dm_idx_r   <= req_off_s[DM_ADDR_W+2:3];
            dm_wdata_r <= bus.req_wdata;
            if (req_err_s) begin
              rsp_rdata_r <= 64'd0;
              rsp_err_r   <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          rsp_rdata_r <= load_data_s;
          rsp_err_r   <= 1'b0;
        end
        ST_WRITE, ST_RMW_WR: begin
          rsp_rdata_r <= 64'd0;
          rsp_err_r   <= 1'b0;
        end
        ST_RMW_RD: dm_wdata_r <= merged_s;
        default: begin
          rsp_err_r <= rsp_err_r;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign im_addr       = addr_r[63:2];
  assign dm_addr       = dm_idx_r;
  assign dm_we         = dm_we_r;
  assign dm_wdata      = dm_wdata_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vectors plus randomized
// traffic checked against a byte-level reference model of the memories.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [61:0] im_addr;
  logic [31:0] im_rdata;
  logic [12:0] dm_addr;
  logic        dm_we;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;

  logic [31:0] im_mem [0:2047];
  logic [63:0] dm_mem [0:8191];
  logic [63:0] ref_dm [0:8191];

  logic        bd_we = 1'b0;
  logic [12:0] bd_idx = 13'd0;
  logic [63:0] bd_data = 64'd0;

  int total = 0;
  int bad = 0;

  mem_bus_ctrl_if bus ();

  mem_bus_ctrl #(.DM_BASE(64'h2000), .DM_ADDR_W(13)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .im_addr (im_addr),
    .im_rdata(im_rdata),
    .dm_addr (dm_addr),
    .dm_we   (dm_we),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  assign im_rdata = im_mem[im_addr[10:0]];
  assign dm_rdata = dm_mem[dm_addr];

  always @(posedge clk) begin
    if (bd_we) dm_mem[bd_idx] <= bd_data;
    else if (dm_we) dm_mem[dm_addr] <= dm_wdata;
  end

  task automatic poke(input int idx, input logic [63:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = 13'(idx); bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_dm[idx] = d;
  endtask

  // One transaction; lat = cycles from accept edge to rsp_valid (9 = timeout)
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er,
                        output int lat, output int wr);
    int w;
    logic got;
    w = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    lat = 0; wr = 0; rd = 64'd0; er = 1'b0; got = 1'b0;
    while (!got && lat < 9) begin
      @(negedge clk);
      lat++;
      bus.req_valid = 1'b0;
      if (dm_we === 1'b1) wr++;
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1; rd = bus.rsp_rdata; er = bus.rsp_err;
      end
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [63:0] a);
    logic [63:0] o;
    if (a < 64'h2000) return im_mem[a[12:2]][8*a[1:0] +: 8];
    o = a - 64'h2000;
    return ref_dm[o[15:3]][8*o[2:0] +: 8];
  endfunction

  // Reference model: byte-addressed view of both memories
  task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, output logic exp_err, output logic [63:0] exp_rd,
                       output int exp_lat, output int exp_wr);
    int size;
    logic in_im;
    logic [63:0] off;
    logic [63:0] ba;
    size  = 1 << f3[1:0];
    in_im = addr < 64'h2000;
    off   = addr - 64'h2000;
    exp_err = (f3 == 3'd7) || ((addr % 64'(size)) != 64'd0) || (we && f3 > 3'd3)
           || (we && in_im) || (size == 8 && in_im) || (!in_im && off >= 64'h10000);
    exp_rd = 64'd0; exp_lat = 1; exp_wr = 0;
    if (!exp_err && !we) begin
      for (int k = 0; k < size; k++) exp_rd = exp_rd | (64'(get_byte(addr + 64'(k))) << (8*k));
      if (f3 < 3'd3 && exp_rd[8*size-1]) exp_rd = exp_rd | ~((64'd1 << (8*size)) - 64'd1);
      exp_lat = 2;
    end else if (!exp_err) begin
      for (int k = 0; k < size; k++) begin
        ba = off + 64'(k);
        ref_dm[ba[15:3]][8*ba[2:0] +: 8] = wd[8*k +: 8];
      end
      exp_lat = (size == 8) ? 2 : 3;
      exp_wr = 1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    total++; if (bus.rsp_rdata !== 64'd0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    total++; if (dm_we !== 1'b0) begin bad++; $display("FAIL reset_dm_we: got %b want 0", dm_we); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_dm_loads;
    logic [2:0]  f3_t  [4] = '{3'd3, 3'd0, 3'd4, 3'd6};
    logic [63:0] a_t   [4] = '{64'h2008, 64'h200F, 64'h200F, 64'h200C};
    logic [63:0] exp_t [4] = '{64'h8877665544332211, 64'hFFFFFFFFFFFFFF88, 64'h88, 64'h88776655};
    logic [63:0] rd; logic er; int lat; int wr;
    poke(1, 64'h8877665544332211);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3_t[i], a_t[i], 64'd0, rd, er, lat, wr);
      total++; if (rd !== exp_t[i] || er !== 1'b0) begin bad++; $display("FAIL dm_load%0d: got %h err %b want %h err 0", i, rd, er, exp_t[i]); end
      total++; if (lat != 2) begin bad++; $display("FAIL dm_load_lat%0d: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_rmw_store;
    logic [63:0] rd; logic er; int lat; int wr;
    poke(2, 64'd0);
    do_req(1'b1, 3'd1, 64'h2012, 64'h1234_5678_9ABC_BEEF, rd, er, lat, wr);
    total++; if (dm_mem[2] !== 64'h00000000BEEF0000) begin bad++; $display("FAIL sh_data: got %h want 00000000beef0000", dm_mem[2]); end
    total++; if (lat != 3 || er !== 1'b0 || wr != 1) begin bad++; $display("FAIL sh_timing: got lat %0d err %b writes %0d want 3 0 1", lat, er, wr); end
  endtask

  task automatic test_reset_abort;
    poke(2, 64'h0123456789ABCDEF);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd1;
    bus.req_addr = 64'h2012; bus.req_wdata = 64'h5A5A;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (dm_we !== 1'b1) begin bad++; $display("FAIL abort_in_rmw_wr: got dm_we %b want 1", dm_we); end
    #1 reset = 1'b1;
    #1;
    total++; if (dm_we !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL abort_outputs: got we %b ready %b valid %b want 0 1 0", dm_we, bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    total++; if (dm_mem[2] !== 64'h0123456789ABCDEF) begin bad++; $display("FAIL abort_mem: got %h want 0123456789abcdef", dm_mem[2]); end
    reset = 1'b0;
  endtask

  task automatic test_im_loads;
    logic [2:0]  f3_t  [3] = '{3'd2, 3'd1, 3'd0};
    logic [63:0] a_t   [3] = '{64'h4, 64'h6, 64'h7};
    logic [63:0] exp_t [3] = '{64'h0000000000500093, 64'h50, 64'h0};
    logic [63:0] rd; logic er; int lat; int wr;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, f3_t[i], a_t[i], 64'd0, rd, er, lat, wr);
      total++; if (rd !== exp_t[i] || er !== 1'b0 || lat != 2) begin
        bad++; $display("FAIL im_load%0d: got %h err %b lat %0d want %h 0 2", i, rd, er, lat, exp_t[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic        we_t [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3_t [5] = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd7};
    logic [63:0] a_t  [5] = '{64'h10, 64'h2002, 64'h0, 64'h12000, 64'h2000};
    logic [63:0] rd; logic er; int lat; int wr;
    for (int i = 0; i < 5; i++) begin
      do_req(we_t[i], f3_t[i], a_t[i], 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat, wr);
      total++; if (er !== 1'b1 || lat != 1 || wr != 0 || rd !== 64'd0) begin
        bad++; $display("FAIL err%0d: got err %b lat %0d writes %0d rdata %h want 1 1 0 0", i, er, lat, wr, rd);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] rd, exp_rd, addr, wd; logic er, exp_err, we; logic [2:0] f3;
    int lat, wr, exp_lat, exp_wr, sel, dm_bad;
    for (int i = 0; i < 8; i++) poke(i, {$urandom, $urandom});
    poke(8191, {$urandom, $urandom});
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      f3  = 3'($urandom_range(0, 7));
      we  = 1'($urandom_range(0, 1));
      wd  = {$urandom, $urandom};
      if (sel < 3) addr = 64'($urandom_range(0, 32'h1FFF));
      else if (sel < 9) addr = 64'h2000 + 64'($urandom_range(0, 63));
      else addr = 64'h11FF8 + 64'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) addr = addr & ~64'((1 << f3[1:0]) - 1);
      model(we, f3, addr, wd, exp_err, exp_rd, exp_lat, exp_wr);
      do_req(we, f3, addr, wd, rd, er, lat, wr);
      total++; if (er !== exp_err || rd !== exp_rd) begin
        bad++; $display("FAIL rnd_rsp n=%0d we=%b f3=%0d addr=%h: got %h err %b want %h err %b", n, we, f3, addr, rd, er, exp_rd, exp_err);
      end
      total++; if (lat != exp_lat || wr != exp_wr) begin
        bad++; $display("FAIL rnd_timing n=%0d: got lat %0d writes %0d want %0d %0d", n, lat, wr, exp_lat, exp_wr);
      end
      dm_bad = 0;
      for (int i = 0; i < 8; i++) if (dm_mem[i] !== ref_dm[i]) dm_bad++;
      if (dm_mem[8191] !== ref_dm[8191]) dm_bad++;
      total++; if (dm_bad != 0) begin bad++; $display("FAIL rnd_mem n=%0d: got %0d differing words want 0", n, dm_bad); end
      @(negedge clk);
      total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== exp_rd) begin
        bad++; $display("FAIL rnd_hold n=%0d: got valid %b rdata %h want 0 %h", n, bus.rsp_valid, bus.rsp_rdata, exp_rd);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 64'd0; bus.req_wdata = 64'd0;
    for (int i = 0; i < 2048; i++) im_mem[i] = $urandom;
    im_mem[1] = 32'h00500093;
    test_reset();
    test_dm_loads();
    test_rmw_store();
    test_reset_abort();
    test_im_loads();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
